// File: rtl/quad_operand_collector_pkg.sv
// rtl/quad_operand_collector_pkg.sv - shared constants and types for the operand collector
package quad_operand_collector_pkg;

    localparam int LANES   = 4;
    localparam int COUNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PEND = 2'd2
    } state_t;

    typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/quad_operand_collector.sv
// rtl/quad_operand_collector.sv - packs a serial byte stream into four-lane groups
module quad_operand_collector
    import quad_operand_collector_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b,
    output logic [DATA_W-1:0]  out_c,
    output logic [DATA_W-1:0]  out_d,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_last
);

    state_t             state;
    state_t             next_state;
    lane_idx_t          idx;
    logic [DATA_W-1:0]  collect [LANES];
    logic [DATA_W-1:0]  group   [LANES];
    logic [COUNT_W-1:0] pend_count;
    logic               pend_last;
    logic [COUNT_W-1:0] close_count;
    logic               accept;
    logic               close;
    logic               slot_free;
    logic               load_close;
    logic               load_pend;

    always_comb begin
        in_ready    = (state != PEND);
        accept      = in_valid & in_ready;
        close       = accept & ((idx == 2'd3) | in_last);
        slot_free   = !out_valid | out_ready;
        load_close  = close & slot_free;
        load_pend   = (state == PEND) & slot_free;
        close_count = {1'b0, idx} + 3'd1;
        // Group view including the byte being accepted; unwritten lanes are already zero.
        for (int i = 0; i < LANES; i++) begin
            group[i] = (accept && (idx == lane_idx_t'(i))) ? in_data : collect[i];
        end

        next_state = state;
        case (state)
            IDLE, FILL: begin
                if (close) begin
                    next_state = slot_free ? IDLE : PEND;
                end else if (accept) begin
                    next_state = FILL;
                end
            end
            PEND: begin
                if (slot_free) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            pend_count <= '0;
            pend_last  <= 1'b0;
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_c      <= '0;
            out_d      <= '0;
            out_count  <= '0;
            out_last   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                collect[i] <= '0;
            end
        end else begin
            if (load_close || load_pend) begin
                out_valid <= 1'b1;
                out_a     <= group[0];
                out_b     <= group[1];
                out_c     <= group[2];
                out_d     <= group[3];
                out_count <= load_close ? close_count : pend_count;
                out_last  <= load_close ? in_last : pend_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (close) begin
                idx <= '0;
                if (slot_free) begin
                    for (int i = 0; i < LANES; i++) begin
                        collect[i] <= '0;
                    end
                end else begin
                    // Slot busy: the closed group parks in the collect buffer until it drains.
                    for (int i = 0; i < LANES; i++) begin
                        collect[i] <= group[i];
                    end
                    pend_count <= close_count;
                    pend_last  <= in_last;
                end
            end else if (accept) begin
                collect[idx] <= in_data;
                idx          <= idx + 2'd1;
            end

            if (load_pend) begin
                for (int i = 0; i < LANES; i++) begin
                    collect[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_operand_collector.sv
// tb/tb_quad_operand_collector.sv - self-checking bench for quad_operand_collector
module tb_quad_operand_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_a, out_b, out_c, out_d;
    logic [2:0] out_count;
    logic       out_last;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    quad_operand_collector #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_count (out_count),
        .out_last  (out_last)
    );

    // Packed view of a group: {count, last, d, c, b, a}
    function automatic logic [35:0] observed();
        return {out_count, out_last, out_d, out_c, out_b, out_a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, observed()} !== 37'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b grp=%h expected all zero", out_valid, observed());
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_full_group();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'((i + 1) * 16); in_last = 1'b0;
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL full_fill_%0d: got ready=%b valid=%b expected ready=1 valid=0", i, in_ready, out_valid);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || observed() !== {3'd4, 1'b0, 8'h40, 8'h30, 8'h20, 8'h10}) begin
            fails++;
            $display("FAIL full_group: got valid=%b grp=%h expected valid=1 grp=%h",
                     out_valid, observed(), {3'd4, 1'b0, 8'h40, 8'h30, 8'h20, 8'h10});
        end
        tick();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_drop: got valid=%b expected 0", out_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[8];
        int ngroups = 0;
        logic [35:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8); in_data = (c < 8) ? b[c] : 8'h00; in_last = 1'b0;
            @(negedge clk);
            if (c < 8) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_ready_%0d: got %b expected 1", c, in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                exp = (ngroups < 2) ? {3'd4, 1'b0, b[4*ngroups+3], b[4*ngroups+2], b[4*ngroups+1], b[4*ngroups]} : 36'd0;
                tests++;
                if (ngroups >= 2 || observed() !== exp) begin
                    fails++;
                    $display("FAIL b2b_group_%0d: got %h expected %h", ngroups, observed(), exp);
                end
                ngroups++;
            end
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (ngroups !== 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d groups expected 2", ngroups);
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] g1 = {3'd4, 1'b0, 8'h44, 8'h33, 8'h22, 8'h11};
        logic [35:0] g2 = {3'd4, 1'b0, 8'h88, 8'h77, 8'h66, 8'h55};
        logic acc;
        int guard;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'((i + 1) * 17); in_last = 1'b0;
            guard = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                if (i >= 4) begin
                    tests++;
                    if (out_valid !== 1'b1 || observed() !== g1) begin
                        fails++;
                        $display("FAIL bp_hold_%0d: got valid=%b grp=%h expected valid=1 grp=%h", i, out_valid, observed(), g1);
                    end
                end
                tick();
                guard++;
            end while (!acc && guard < 20);
            if (!acc) begin
                tests++; fails++;
                $display("FAIL bp_accept_timeout_%0d: got in_ready=0 expected 1 within 20 cycles", i);
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || observed() !== g1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_pend_%0d: got valid=%b grp=%h ready=%b expected valid=1 grp=%h ready=0",
                         k, out_valid, observed(), in_ready, g1);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || observed() !== g2 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got valid=%b grp=%h ready=%b expected valid=1 grp=%h ready=1",
                     out_valid, observed(), in_ready, g2);
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: got valid=%b expected 0", out_valid);
        end
        tick();
    endtask

    task automatic test_partial();
        int ns[4] = '{2, 1, 3, 4};
        logic [7:0] b[4];
        logic [35:0] exp;
        int n;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            n = ns[c];
            for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
            if (c == 0) begin b[0] = 8'hAA; b[1] = 8'hBB; end
            for (int i = 0; i < n; i++) begin
                in_valid = 1'b1; in_data = b[i]; in_last = (i == n - 1);
                tick();
            end
            in_valid = 1'b0; in_last = 1'b0;
            exp = {3'(n), 1'b1, (n > 3) ? b[3] : 8'h00, (n > 2) ? b[2] : 8'h00,
                   (n > 1) ? b[1] : 8'h00, b[0]};
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || observed() !== exp) begin
                fails++;
                $display("FAIL partial_n%0d: got valid=%b grp=%h expected valid=1 grp=%h", n, out_valid, observed(), exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'hE0 + 8'(i); in_last = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 4); in_data = 8'(c + 1);
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen++;
                tests++;
                if (observed() !== {3'd4, 1'b0, 8'h04, 8'h03, 8'h02, 8'h01}) begin
                    fails++;
                    $display("FAIL rstmid_group: got %h expected %h", observed(), {3'd4, 1'b0, 8'h04, 8'h03, 8'h02, 8'h01});
                end
            end
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (seen !== 1) begin
            fails++;
            $display("FAIL rstmid_count: got %0d groups expected 1", seen);
        end
        // Reset while a group is pending must discard it.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i); tick();
        end
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstpend: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
        tick(); tick();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstpend_quiet: got valid=%b expected 0", out_valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic [35:0] exp_q[$];
        logic [7:0]  cur[$];
        logic [7:0]  l[4];
        logic [35:0] got, held, exp;
        logic        holding = 1'b0;
        int sent = 0;
        int cyc = 0;
        int groups = 0;
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            if (sent < 1000) begin
                in_valid = ($urandom % 10) < 7;
                in_data  = 8'($urandom);
                in_last  = (sent == 999) || (($urandom % 10) == 0);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            out_ready = ($urandom % 10) < 6;
            @(negedge clk);
            got = observed();
            if (holding) begin
                tests++;
                if (out_valid !== 1'b1 || got !== held) begin
                    fails++;
                    $display("FAIL rand_stable: got valid=%b grp=%h expected valid=1 grp=%h", out_valid, got, held);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra: got grp=%h expected no group", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL rand_group_%0d: got %h expected %h", groups, got, exp);
                    end
                end
                groups++;
            end
            holding = (out_valid === 1'b1) && !out_ready;
            held = got;
            if (in_valid && in_ready === 1'b1) begin
                cur.push_back(in_data);
                sent++;
                if (cur.size() == 4 || in_last) begin
                    for (int i = 0; i < 4; i++) l[i] = (i < cur.size()) ? cur[i] : 8'h00;
                    exp_q.push_back({3'(cur.size()), in_last, l[3], l[2], l[1], l[0]});
                    cur.delete();
                end
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        tests++;
        if (sent != 1000 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL rand_complete: got sent=%0d outstanding=%0d expected sent=1000 outstanding=0", sent, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_back_to_back();
        test_backpressure();
        test_partial();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
